// File: rtl/led_fade_if.sv
// led_fade_if: bundles the pattern-side target vector and the LED-side
// outputs of led_fade_driver.
//   target : per-channel goal (1 = fade to full, 0 = fade to off)
//   led    : registered PWM drive, active high
//   busy   : registered, high while any channel is short of its endpoint
// master = pattern logic / bench, slave = led_fade_driver.
interface led_fade_if #(
  parameter int CHANNELS = 5
);
  logic [CHANNELS-1:0] target;
  logic [CHANNELS-1:0] led;
  logic                busy;

  modport master (output target, input  led, input  busy);
  modport slave  (input  target, output led, output busy);
endinterface

// File: rtl/led_fade_driver.sv
// led_fade_driver: per-LED linear brightness fader with PWM output.
// Each channel's level moves one step toward 0 or MAX on every step_tick
// and is compared against a shared free-running PWM counter.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : led_fade_if.slave (target in, led/busy out)

// One channel: saturating level ramp plus registered PWM compare.
module led_fade_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_tick,
  input  logic                target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                mismatch
);
  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q, led_d;

  always_comb begin
    level_d = level_q;
    if (step_tick) begin
      if (target && level_q != MAX)       level_d = level_q + 1'b1;
      else if (!target && level_q != '0)  level_d = level_q - 1'b1;
    end
    // MAX term keeps the LED solid at full brightness; the compare alone
    // would leave one dark cycle per period.
    led_d    = (level_q == MAX) | (level_q > pwm_cnt);
    mismatch = (level_q != (target ? MAX : '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;
endmodule

module led_fade_driver #(
  parameter int CHANNELS = 5,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 24000
) (
  input  logic          clk,
  input  logic          rst,
  led_fade_if.slave     bus
);
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                busy_q, busy_d;
  logic                step_tick;
  logic [CHANNELS-1:0] led;
  logic [CHANNELS-1:0] mismatch;

  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + 1'b1;  // wraps MAX->0 naturally
    step_tick  = (step_cnt_q == STEP_W'(STEP_DIV - 1));
    step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
    busy_d     = |mismatch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      busy_q     <= busy_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    led_fade_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .step_tick(step_tick),
      .target   (bus.target[i]),
      .pwm_cnt  (pwm_cnt_q),
      .led      (led[i]),
      .mismatch (mismatch[i])
    );
  end

  assign bus.led  = led;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_led_fade_driver.sv
module tb_led_fade_driver;
  localparam int CH = 5;
  localparam int PB = 4;
  localparam int SD = 3;
  localparam int MAXV = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  led_fade_if #(.CHANNELS(CH)) bus ();
  led_fade_if #(.CHANNELS(CH)) bus2 ();

  led_fade_driver #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(SD)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  // Slow-stepping instance so a level can be held across a whole PWM period.
  led_fade_driver #(.CHANNELS(CH), .PWM_BITS(PB), .STEP_DIV(40)) u_dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  typedef struct packed {
    logic [CH-1:0] led;
    logic          busy;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   d2_done = 0;

  // Reference state of the spec behaviour.
  int m_pwm, m_step;
  int m_lvl [CH];
  int cyc_tag;

  task automatic step(input logic r, input logic [CH-1:0] t);
    exp_t e;
    logic tick;
    rst = r;
    bus.target = t;
    e = '0;
    if (r) begin
      m_pwm = 0; m_step = 0;
      for (int i = 0; i < CH; i++) m_lvl[i] = 0;
    end else begin
      tick = (m_step == SD - 1);
      for (int i = 0; i < CH; i++) begin
        e.led[i] = (m_lvl[i] == MAXV) || (m_lvl[i] > m_pwm);
        if (m_lvl[i] != (t[i] ? MAXV : 0)) e.busy = 1'b1;
        if (tick) begin
          if (t[i] && m_lvl[i] < MAXV) m_lvl[i]++;
          else if (!t[i] && m_lvl[i] > 0) m_lvl[i]--;
        end
      end
      m_pwm  = (m_pwm + 1) % (MAXV + 1);
      m_step = tick ? 0 : m_step + 1;
    end
    @(posedge clk); #1;
    sbq.push_back(e);
    cyc_tag++;
  endtask

  task automatic run(input logic [CH-1:0] t, input int n);
    for (int k = 0; k < n; k++) step(1'b0, t);
  endtask

  // Monitor: outputs are valid every cycle; compare each expected entry.
  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (bus.led !== e.led || bus.busy !== e.busy) begin
        errors++;
        $display("FAIL sb cyc=%0d led=%b busy=%b expected led=%b busy=%b",
                 cyc_tag, bus.led, bus.busy, e.led, e.busy);
      end
    end
  end

  // Duty check on the slow instance: level 8 held through cycles 321..360.
  initial begin : dut2_seq
    int hi0, hi1;
    hi0 = 0; hi1 = 0;
    bus2.target = '0;
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    bus2.target = 5'b00001;
    for (int c = 1; c <= 350; c++) begin
      @(posedge clk); #1;
      if (c == 330) bus2.target = 5'b00000;
      if (c >= 330 && c <= 345) begin
        hi0 += int'(bus2.led[0]);
        hi1 += int'(bus2.led[1]);
      end
      if (c == 346) begin
        checks++;
        if (bus2.busy !== 1'b1) begin
          errors++;
          $display("FAIL dut2_busy got=%b expected=1", bus2.busy);
        end
      end
    end
    checks++;
    if (hi0 != 8) begin
      errors++;
      $display("FAIL duty_lvl8 got=%0d expected=8", hi0);
    end
    checks++;
    if (hi1 != 0) begin
      errors++;
      $display("FAIL duty_lvl0 got=%0d expected=0", hi1);
    end
    d2_done = 1;
  end

  initial begin : main_seq
    bit ok;
    cyc_tag = 0;
    bus.target = '0;
    // 1: reset with all targets high, then release
    for (int k = 0; k < 4; k++) step(1'b1, 5'b11111);
    run(5'b11111, 20);
    // 2: single channel full ramp up and saturation
    step(1'b1, 5'b00001);
    run(5'b00001, 52);
    // 3: short low pulse mid-ramp that misses a step tick
    step(1'b1, 5'b00001);
    run(5'b00001, 24);
    run(5'b00000, 2);
    run(5'b00001, 20);
    // 4: reversal at level 5 and hold at 0
    step(1'b1, 5'b00001);
    run(5'b00001, 15);
    run(5'b00000, 15);
    run(5'b00000, 30);
    // 5: reset mid-ramp at level 10
    step(1'b1, 5'b00001);
    run(5'b00001, 30);
    step(1'b1, 5'b00001);
    run(5'b00001, 10);
    // 6: spinner swaps with channel 4 held high
    step(1'b1, 5'b10000);
    for (int s = 0; s < 6; s++) run((s % 2 == 0) ? 5'b11010 : 5'b10101, 60);
    @(negedge clk);
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      if (d2_done) begin ok = 1; break; end
      @(posedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL dut2_timeout got=0 expected=1");
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_fade_driver.md
# led_fade_driver

Downstream stage for the LED spinner on the FPGA test board. It takes the spinner's per-LED on/off pattern as targets and drives the physical LED pins with PWM. Each LED ramps its brightness linearly toward fully on or fully off instead of switching hard. It sits between the pattern logic and the top-level LED outputs, in the same clock domain.

## Interface
- CHANNELS, 5, number of LED channels
- PWM_BITS, 8, brightness and PWM counter width; MAX = 2^PWM_BITS-1
- STEP_DIV, 24000, clock cycles per brightness step (>=1); at 12 MHz a full ramp takes about 0.51 s

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- target  input  CHANNELS  per-channel goal: 1 = ramp to MAX, 0 = ramp to 0; same clock domain, no synchronizer
- led  output  CHANNELS  registered PWM drive to LED pins, active high
- busy  output  1  registered; 1 while any channel level differs from its target endpoint

## Operation
- pwm_cnt (PWM_BITS wide): free-running, +1 every clk, wraps MAX->0.
- step_cnt: counts 0..STEP_DIV-1, then returns to 0.
  - step_tick = (step_cnt == STEP_DIV-1), combinational, high one cycle per STEP_DIV.
  - With STEP_DIV = 1, step_tick is high every cycle.
- level[i] (PWM_BITS wide), updated only on step_tick:
  - target[i]=1 and level<MAX: level+1.
  - target[i]=0 and level>0: level-1.
  - Otherwise hold. Saturating, never wraps.
- Target change mid-ramp: the next step_tick moves level from its current value in the new direction. There is no restart and no pause.
- Target pulses shorter than STEP_DIV cycles: only the value present on a tick cycle has effect.
- led[i] <= (level[i] == MAX) | (level[i] > pwm_cnt).
  - level 0 gives constant 0.
  - level MAX gives constant 1.
  - level k (0<k<MAX) gives exactly k high cycles per 2^PWM_BITS-cycle PWM period.
- busy <= OR over i of (level[i] != (target[i] ? MAX : 0)).
- Channels are fully independent. Simultaneous opposite-direction ramps on different channels are legal.
- Reset while rst=1, at every edge: pwm_cnt=0, step_cnt=0, all level=0, led=0, busy=0. Target is ignored. Reset mid-ramp discards all state.

## Timing
- Outputs are fully registered.
  - led and busy at edge t+1 reflect level, pwm_cnt and target as they stood in cycle t.
- First step_tick after rst falls is in the STEP_DIV-th cycle; level changes at the end of that cycle.
- Full ramp 0->MAX (or MAX->0): MAX*STEP_DIV cycles from reset release or from the target change that starts it. The exact offset depends on the step_cnt phase, which is never realigned by target.
- busy falls one cycle after the last level step that reaches its endpoint.
- busy rises one cycle after a target change that creates a mismatch.
- pwm_cnt phase is independent of step_cnt and of target.

## Test plan
Use PWM_BITS=4, STEP_DIV=3, CHANNELS=5 unless noted.
1. Reset: rst=1 for 4 cycles with target=5'b11111, then release.
   - During reset: led=0, busy=0.
   - One cycle after release: busy=1.
   - First led[0] pulse appears after level reaches 1, at cycle 3.
2. Ramp up: target=5'b00001 from reset release.
   - level[0] reaches 15 after 45 cycles, and led[0] is constant 1 from the next cycle.
   - busy=0 from cycle 46.
   - led[4:1] stay 0 throughout.
3. Duty: ramp for 24 cycles (level 8), then drop target to 0 for 2 cycles and return to 1 within one step period.
   - Check led[0] is high exactly 8 of 16 cycles in a full PWM period.
   - A level-0 channel shows 0 high cycles.
4. Reversal and saturation: ramp channel 0 to level 5, then set target=0.
   - Level decrements 5->0 over 15 cycles, then holds at 0; no wrap to 15 after a further 30 cycles.
   - led[0]=0 thereafter; busy=0.
5. Reset mid-ramp: assert rst for 1 cycle at level 10.
   - Next cycle: led=0, busy=0.
   - After release, the ramp restarts from 0 with the first step STEP_DIV cycles later.
6. Spinner pattern: target alternates 4'b1010 and 4'b0101 (LED5 held at 1) every 60 cycles.
   - Channels 0-3 ramp in opposite directions simultaneously, each reaching its endpoint within 45 cycles.
   - led[4] is constant 1 once channel 4 is saturated.
   - busy pulses high after each swap.
